computer_node: RTL and testbench
================================

Name: computer_node

Overview:
- Processing node ("Computer") in the photonic-interconnect multiprocessor.
- Accepts a transfer command on the control channel and tunes its receiver to the named source node.
- Captures a block of N 16-bit data words, sums them locally, then broadcasts the result on its own control and data transmit channels.
- One instance per network node; the node identity and node count are supplied as ports.

Parameters:
- DEPTH, 16, capacity of the local receive buffer in words; maximum accepted N.
- WORD_W, 16, payload width in bits; fixed at 16 by the packet format.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- node_id  in  16  this node's ID, signed 16-bit (shortint); valid IDs are 1..max_node.
- max_node  in  16  number of nodes in the network, signed 16-bit.
- control_rx_packet  in  32  control packet: [31:16] source node S, [15:0] word count N; 0 = idle.
- control_tx_packet  out  32  outgoing control packet, same format.
- data_rx_node_id  out  16  source node the data receiver is tuned to; 0 = not listening.
- data_rx_packet  in  32  data packet: [31:16] sender ID, [15:0] payload; 0 = idle.
- data_tx_packet  out  32  outgoing data packet, same format.

Behaviour:
- Reset, sampled when rst=0 at a clk edge:
  - state IDLE; all outputs 0; buffer count and accumulator 0.
  - Reset has priority in every state and aborts any transfer in progress.
- X/Z on the rx inputs is treated as not matching.
- All outputs are registered.
- IDLE:
  - Accept a control packet when S is in 1..max_node, 1<=N<=DEPTH, and the node is in IDLE. S==node_id (loopback) is allowed.
  - On accept: latch S and N; data_rx_node_id<=S; go to WAIT_HDR.
  - Otherwise the packet is ignored.
  - Control packets arriving outside IDLE are ignored.
- WAIT_HDR:
  - The next data packet with [31:16]==S is a header; its [15:0] must equal N.
  - Header matches -> RECV.
  - Header mismatches -> abort: data_rx_node_id<=0, go to IDLE.
  - Packets from other senders and idle packets are ignored.
  - There is no timeout.
- RECV:
  - Each data packet with [31:16]==S stores [15:0] into buffer[count]; count increments.
  - Gaps (non-matching packets) are allowed.
  - After the N-th word: data_rx_node_id<=0, go to COMPUTE.
- COMPUTE:
  - Accumulates one buffer word per cycle, so it takes N cycles.
  - The sum is 16-bit and wraps modulo 2^16.
  - Then go to TX_CTRL.
- TX_CTRL (1 cycle): control_tx_packet={node_id,16'h0001}.
- TX_HDR (1 cycle): data_tx_packet={node_id,16'h0001}; control_tx_packet back to 0.
- TX_DATA (1 cycle): data_tx_packet={node_id,sum}.
- Then IDLE with all outputs 0.
- Outside the TX states, control_tx_packet and data_tx_packet are 0.
- Latency from the last payload edge to the TX_DATA output is N+3 cycles.
- A control packet present in the same cycle the node returns to IDLE is not accepted; acceptance starts on the next edge in IDLE.

Decomposition:
- Package computer_pkg holds:
  - state enum: IDLE, WAIT_HDR, RECV, COMPUTE, TX_CTRL, TX_HDR, TX_DATA;
  - packet struct {logic [15:0] id; logic [15:0] payload};
  - constant IDLE_PKT = 32'h0.
- One sub-module, computer_rx_buffer: DEPTH x 16 register file with write port (wr_en, wr_addr, wr_data) and one combinational read port.
- The top level holds the FSM, accumulator and TX output registers.

Test Plan:
- Nominal transfer:
  - Stimulus: node_id=1, max_node=4; release reset; control 0x00010004 for 1 cycle, then 0; data 0x00010004, 0x0001000A, 0x0001000B, 0x0001000C, 0x0001000D on consecutive cycles, then 0.
  - Response: data_rx_node_id=1 from the cycle after the control packet until the last payload; control_tx=0x00010001 for one cycle, then data_tx=0x00010001, then data_tx=0x0001002E; all outputs 0 afterwards.
- Rejects:
  - Control 0x00050004 (S > max_node): no change; data_rx_node_id stays 0.
  - Control 0x00010000 (N=0): no change.
  - Control 0x00010011 (N > DEPTH): no change.
- Header mismatch: control 0x00020003 then data 0x00020004 -> return to IDLE; data_rx_node_id=0; no TX.
- Filtering and wrap:
  - Stimulus: control 0x00030002; header 0x00030002; interleaved 0x0002FFFF; payloads 0x0003FFFF, 0x00030003.
  - Response: the 0x0002FFFF word is ignored; sum wraps to 0x0002; data_tx=0x00010002.
- Mid-transfer reset: drive rst=0 for 1 cycle during RECV -> all outputs 0 next edge; a subsequent full transfer completes correctly.
- Busy: a second control packet during RECV or COMPUTE is ignored and the first transfer completes unchanged.

Source files
------------

// File: rtl/computer_pkg.sv
// computer_pkg: shared states, packet layout and helpers for the processing node
package computer_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_HDR,
    RECV,
    COMPUTE,
    TX_CTRL,
    TX_HDR,
    TX_DATA
  } state_t;
  typedef struct packed {
    logic [15:0] id;
    logic [15:0] payload;
  } packet_t;
  localparam logic [31:0] IDLE_PKT = 32'h0;
  function automatic packet_t make_pkt(input logic [15:0] id, input logic [15:0] payload);
    return '{id: id, payload: payload};
  endfunction
endpackage

// File: rtl/computer_rx_buffer.sv
// computer_rx_buffer: receive word store with one write port and a combinational read port
module computer_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int WORD_W = 16,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  // store one payload word per accepted data packet
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/computer_node.sv
// computer_node: receives a block of words from a named source, sums them and broadcasts the result
module computer_node
  import computer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WORD_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [15:0] max_node,
  input  logic [31:0] control_rx_packet,
  output logic [31:0] control_tx_packet,
  output logic [15:0] data_rx_node_id,
  input  logic [31:0] data_rx_packet,
  output logic [31:0] data_tx_packet
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  state_t state_q, state_d;
  logic [15:0] src_q, src_d, n_q, n_d, cnt_q, cnt_d, rxid_q, rxid_d;
  logic [WORD_W-1:0] acc_q, acc_d, rd_data;
  packet_t ctx_q, ctx_d, dtx_q, dtx_d, crx, drx;
  logic we, ctrl_ok, hit, last;
  assign crx = control_rx_packet;
  assign drx = data_rx_packet;
  assign ctrl_ok = $signed(crx.id) >= 16'sd1 && $signed(crx.id) <= $signed(max_node) &&
                   crx.payload != 16'h0 && crx.payload <= DEPTH_W;
  assign hit = drx.id == src_q;
  assign last = cnt_q + 16'd1 == n_q;
  computer_rx_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_buf (
    .clk    (clk),
    .wr_en  (we),
    .wr_addr(cnt_q[AW-1:0]),
    .wr_data(drx.payload),
    .rd_addr(cnt_q[AW-1:0]),
    .rd_data(rd_data)
  );
  // transfer sequencing, accumulation and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    n_d = n_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    rxid_d = rxid_q;
    ctx_d = IDLE_PKT;
    dtx_d = IDLE_PKT;
    we = 1'b0;
    case (state_q)
      IDLE: if (ctrl_ok) begin
        src_d = crx.id;
        n_d = crx.payload;
        rxid_d = crx.id;
        cnt_d = '0;
        acc_d = '0;
        state_d = WAIT_HDR;
      end
      WAIT_HDR: if (hit) begin
        state_d = drx.payload == n_q ? RECV : IDLE;
        rxid_d = drx.payload == n_q ? src_q : 16'h0;
      end
      RECV: if (hit) begin
        we = 1'b1;
        cnt_d = last ? '0 : cnt_q + 16'd1;
        rxid_d = last ? 16'h0 : rxid_q;
        state_d = last ? COMPUTE : RECV;
      end
      COMPUTE: begin
        acc_d = acc_q + rd_data;
        cnt_d = last ? '0 : cnt_q + 16'd1;
        state_d = last ? TX_CTRL : COMPUTE;
      end
      TX_CTRL: begin
        ctx_d = make_pkt(node_id, 16'h0001);
        state_d = TX_HDR;
      end
      TX_HDR: begin
        dtx_d = make_pkt(node_id, 16'h0001);
        state_d = TX_DATA;
      end
      TX_DATA: begin
        dtx_d = make_pkt(node_id, acc_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any transfer in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      rxid_q <= '0;
      ctx_q <= IDLE_PKT;
      dtx_q <= IDLE_PKT;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      rxid_q <= rxid_d;
      ctx_q <= ctx_d;
      dtx_q <= dtx_d;
    end
  end
  assign control_tx_packet = ctx_q;
  assign data_tx_packet = dtx_q;
  assign data_rx_node_id = rxid_q;
endmodule

// File: tb/tb_computer_node.sv
// tb_computer_node: directed and random transfers checked against a transaction-level model
module tb_computer_node;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] node_id = 16'd1;
  logic [15:0] max_node = 16'd4;
  logic [31:0] crx = 32'h0;
  logic [31:0] drx = 32'h0;
  logic [31:0] ctx, dtx;
  logic [15:0] rxid;
  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;
  int cyc = 0;
  bit listen = 1'b0;
  bit got_hdr = 1'b0;
  logic [15:0] ms = 16'h0;
  logic [15:0] mn = 16'h0;
  logic [15:0] msum = 16'h0;
  logic [15:0] words[$];
  int tx_base = -1;
  logic [31:0] e_ctrl = 32'h0;
  logic [31:0] e_data = 32'h0;
  logic [15:0] e_rxid = 16'h0;
  int lat;

  always #5 clk = ~clk;

  computer_node dut (
    .clk(clk),
    .rst(rst),
    .node_id(node_id),
    .max_node(max_node),
    .control_rx_packet(crx),
    .control_tx_packet(ctx),
    .data_rx_node_id(rxid),
    .data_rx_packet(drx),
    .data_tx_packet(dtx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit accept(input logic [31:0] c);
    int s, mx, n;
    s = int'($signed(c[31:16]));
    mx = int'($signed(max_node));
    n = int'(c[15:0]);
    return s >= 1 && s <= mx && n >= 1 && n <= 16;
  endfunction

  // Advance the model over the coming clock edge, using the inputs that edge will sample.
  task model_edge();
    cyc++;
    if (rst !== 1'b1) begin
      listen = 1'b0;
      tx_base = -1;
      words.delete();
      e_ctrl = 32'h0;
      e_data = 32'h0;
      e_rxid = 16'h0;
      return;
    end
    if (tx_base >= 0 && cyc > tx_base + int'(mn) + 3) tx_base = -1;
    if (listen) begin
      if (drx[31:16] === ms) begin
        if (!got_hdr) begin
          if (drx[15:0] === mn) got_hdr = 1'b1;
          else listen = 1'b0;
        end else begin
          words.push_back(drx[15:0]);
          if (words.size() == int'(mn)) begin
            listen = 1'b0;
            tx_base = cyc;
            msum = 16'h0;
            foreach (words[i]) msum += words[i];
          end
        end
      end
    end else if (tx_base < 0 && accept(crx)) begin
      listen = 1'b1;
      got_hdr = 1'b0;
      ms = crx[31:16];
      mn = crx[15:0];
      words.delete();
    end
    e_rxid = listen ? ms : 16'h0;
    e_ctrl = (tx_base >= 0 && cyc == tx_base + int'(mn) + 1) ? {node_id, 16'h0001} : 32'h0;
    e_data = (tx_base >= 0 && cyc == tx_base + int'(mn) + 2) ? {node_id, 16'h0001} :
             (tx_base >= 0 && cyc == tx_base + int'(mn) + 3) ? {node_id, msum} : 32'h0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("control_tx", ctx, e_ctrl);
        check("data_tx", dtx, e_data);
        check("data_rx_node_id", {16'h0, rxid}, {16'h0, e_rxid});
      end
      model_edge();
    end
  end

  task step(input logic [31:0] c, input logic [31:0] d);
    crx = c;
    drx = d;
    @(posedge clk);
    #2;
  endtask

  task wait_data(input logic [31:0] exp, output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      step(32'h0, 32'h0);
      if (dtx === exp) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    armed = 1'b1;
    check("reset_ctrl", ctx, 32'h0);
    check("reset_data", dtx, 32'h0);
    check("reset_rxid", {16'h0, rxid}, 32'h0);
    rst = 1'b1;
    step(32'h00010004, 32'h0);
    check("nom_tuned", {16'h0, rxid}, 32'h1);
    step(32'h0, 32'h00010004);
    step(32'h0, 32'h0001000A);
    step(32'h0, 32'h0001000B);
    step(32'h0, 32'h0001000C);
    step(32'h0, 32'h0001000D);
    check("nom_untuned", {16'h0, rxid}, 32'h0);
    wait_data(32'h0001002E, lat);
    check("nom_latency", lat, 32'd7);
    check("nom_model_sum", {16'h0, msum}, 32'h2E);
    repeat (3) step(32'h0, 32'h0);
    step(32'h00050004, 32'h0);
    check("rej_src", {16'h0, rxid}, 32'h0);
    step(32'h00010000, 32'h0);
    check("rej_n0", {16'h0, rxid}, 32'h0);
    step(32'h00010011, 32'h0);
    check("rej_depth", {16'h0, rxid}, 32'h0);
    step(32'h0, 32'h0);
    step(32'h00020003, 32'h0);
    check("hdr_tuned", {16'h0, rxid}, 32'h2);
    step(32'h0, 32'h00020004);
    check("hdr_abort", {16'h0, rxid}, 32'h0);
    repeat (6) step(32'h0, 32'h0);
    step(32'h00030002, 32'h0);
    step(32'h0, 32'h00030002);
    step(32'h0, 32'h0002FFFF);
    step(32'h0, 32'h0003FFFF);
    step(32'h0, 32'h00030003);
    wait_data(32'h00010002, lat);
    check("wrap_latency", lat, 32'd5);
    repeat (2) step(32'h0, 32'h0);
    step(32'h00010003, 32'h0);
    step(32'h0, 32'h00010003);
    step(32'h0, 32'h00010005);
    rst = 1'b0;
    step(32'h0, 32'h00010006);
    rst = 1'b1;
    check("midrst_ctrl", ctx, 32'h0);
    check("midrst_data", dtx, 32'h0);
    check("midrst_rxid", {16'h0, rxid}, 32'h0);
    step(32'h00010003, 32'h0);
    step(32'h0, 32'h00010003);
    step(32'h0, 32'h00010001);
    step(32'h0, 32'h00010002);
    step(32'h0, 32'h00010003);
    wait_data(32'h00010006, lat);
    check("after_rst_latency", lat, 32'd6);
    repeat (2) step(32'h0, 32'h0);
    step(32'h00010002, 32'h0);
    step(32'h0, 32'h00010002);
    step(32'h00020001, 32'h00010007);
    step(32'h00030001, 32'h00010008);
    step(32'h00010001, 32'h0);
    wait_data(32'h0001000F, lat);
    check("busy_latency", lat, 32'd4);
    repeat (3) step(32'h0, 32'h0);
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] c, d;
      int r;
      c = 32'h0;
      if ($urandom_range(0, 5) == 0)
        c = {($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 5)),
             16'($urandom_range(0, 18))};
      r = $urandom_range(0, 3);
      if (r == 0) d = 32'h0;
      else if (r == 1 || !listen) d = {16'($urandom_range(0, 4)), 16'($urandom)};
      else if (!got_hdr) d = {ms, ($urandom_range(0, 4) != 0) ? mn : 16'($urandom_range(0, 18))};
      else d = {ms, 16'($urandom)};
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(c, d);
    end
    rst = 1'b1;
    repeat (30) step(32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
